// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer in front of the single-port memory_unit.
// Optional feature: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking instead of fixed port-0 priority.
module mem_arbiter #(
  parameter int DATAWIDTH = 8,
  parameter int MAX_LOCK  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [DATAWIDTH-1:0] addr0,
  input  logic [DATAWIDTH-1:0] addr1,
  input  logic [DATAWIDTH-1:0] wdata0,
  input  logic [DATAWIDTH-1:0] wdata1,
  input  logic                 lock0,
  input  logic                 lock1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic [DATAWIDTH-1:0] rdata0,
  output logic [DATAWIDTH-1:0] rdata1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [DATAWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_wdata,
  output logic                 mem_write,
  input  logic [DATAWIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOCK);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } own_t;

  own_t          own_r;
  own_t          own_nxt_s;
  logic          last_r;
  logic          last_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          win1_s;
  logic          any_req_s;
  logic          gnt0_s;
  logic          gnt1_s;
  logic          brk_s;
  logic          rd0_s;
  logic          rd1_s;

  // Normal arbitration winner: lone requester, else tie-break (port != last when round-robin).
  always_comb begin
    any_req_s = req0 | req1;
    if (req0 && req1) begin
      win1_s = RR_EN & ~last_r;
    end else begin
      win1_s = req1;
    end
  end

  // Grant selection including lock hold and forced lock break.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    brk_s  = 1'b0;
    case (own_r)
      LOCK0: begin
        if (req0) begin
          if ((cnt_r >= MAX_CNT) && req1) begin
            brk_s  = 1'b1;
            gnt1_s = 1'b1;
          end else begin
            gnt0_s = 1'b1;
          end
        end else begin
          gnt0_s = any_req_s & ~win1_s;
          gnt1_s = any_req_s & win1_s;
        end
      end
      LOCK1: begin
        if (req1) begin
          if ((cnt_r >= MAX_CNT) && req0) begin
            brk_s  = 1'b1;
            gnt0_s = 1'b1;
          end else begin
            gnt1_s = 1'b1;
          end
        end else begin
          gnt0_s = any_req_s & ~win1_s;
          gnt1_s = any_req_s & win1_s;
        end
      end
      default: begin
        gnt0_s = any_req_s & ~win1_s;
        gnt1_s = any_req_s & win1_s;
      end
    endcase
    if (!rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      brk_s  = 1'b0;
    end else begin
      brk_s = brk_s;
    end
  end

  // Ownership, lock counter and round-robin pointer next state.
  always_comb begin
    own_nxt_s  = own_r;
    cnt_nxt_s  = cnt_r;
    last_nxt_s = last_r;
    if (brk_s) begin
      own_nxt_s  = IDLE;
      cnt_nxt_s  = {CW{1'b0}};
      last_nxt_s = gnt1_s;
    end else if (gnt0_s) begin
      last_nxt_s = 1'b0;
      if (lock0) begin
        own_nxt_s = LOCK0;
        if (own_r == LOCK0) begin
          cnt_nxt_s = (req1 && (cnt_r < MAX_CNT)) ? cnt_r + CW'(1'b1) : cnt_r;
        end else begin
          cnt_nxt_s = req1 ? CW'(1'b1) : {CW{1'b0}};
        end
      end else begin
        own_nxt_s = IDLE;
        cnt_nxt_s = {CW{1'b0}};
      end
    end else if (gnt1_s) begin
      last_nxt_s = 1'b1;
      if (lock1) begin
        own_nxt_s = LOCK1;
        if (own_r == LOCK1) begin
          cnt_nxt_s = (req0 && (cnt_r < MAX_CNT)) ? cnt_r + CW'(1'b1) : cnt_r;
        end else begin
          cnt_nxt_s = req0 ? CW'(1'b1) : {CW{1'b0}};
        end
      end else begin
        own_nxt_s = IDLE;
        cnt_nxt_s = {CW{1'b0}};
      end
    end else begin
      // No grant means the lock owner (if any) has stopped requesting.
      own_nxt_s = IDLE;
      cnt_nxt_s = {CW{1'b0}};
    end
  end

  // Memory drive: granted port's address/data, port 0 when idle.
  always_comb begin
    if (gnt1_s) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end else begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end
    mem_write = (gnt0_s & we0) | (gnt1_s & we1);
    gnt0      = gnt0_s;
    gnt1      = gnt1_s;
    rd0_s     = gnt0_s & ~we0;
    rd1_s     = gnt1_s & ~we1;
  end

  // Arbiter state and registered read-data return.
  always_ff @(posedge clk) begin
    if (!rst) begin
      own_r   <= IDLE;
      last_r  <= 1'b1;
      cnt_r   <= {CW{1'b0}};
      rdata0  <= {DATAWIDTH{1'b0}};
      rdata1  <= {DATAWIDTH{1'b0}};
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      own_r   <= own_nxt_s;
      last_r  <= last_nxt_s;
      cnt_r   <= cnt_nxt_s;
      rvalid0 <= rd0_s;
      rvalid1 <= rd1_s;
      if (rd0_s) begin
        rdata0 <= mem_rdata;
      end
      if (rd1_s) begin
        rdata1 <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed vectors push expected read data, a negedge monitor pops on rvalid.
module tb_mem_arbiter;

  localparam int DW = 8;
  localparam int ML = 4;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [DW-1:0] addr0, addr1, wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_write;
  logic [DW-1:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  logic [DW-1:0] e0, e1;
  int            checks = 0;
  int            errors = 0;
  logic          t1;

  always #5 clk = ~clk;

  mem_arbiter #(.DATAWIDTH(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  // Memory model: mem[i]=i except mem[0x10]=0xA5, reloaded during reset.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      mem[8'h10] <= 8'hA5;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid must match the oldest expected read for that port.
  always @(negedge clk) begin
    if (rvalid0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL rvalid0_unexpected: got rdata0=0x%0h expected no rvalid", rdata0);
      end else begin
        e0 = q0.pop_front();
        chk("rdata0", {24'h0, rdata0}, {24'h0, e0});
      end
    end
    if (rvalid1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL rvalid1_unexpected: got rdata1=0x%0h expected no rvalid", rdata1);
      end else begin
        e1 = q1.pop_front();
        chk("rdata1", {24'h0, rdata1}, {24'h0, e1});
      end
    end
  end

  task automatic drv(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0, input logic l0,
                     input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1, input logic l1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
  endtask

  task automatic step(input string nm, input logic eg0, input logic eg1, input logic emw,
                      input logic [7:0] eaddr, input logic [7:0] erd);
    #1;
    chk({nm, "_gnt0"}, {31'h0, gnt0}, {31'h0, eg0});
    chk({nm, "_gnt1"}, {31'h0, gnt1}, {31'h0, eg1});
    chk({nm, "_mem_write"}, {31'h0, mem_write}, {31'h0, emw});
    if (eg0 || eg1) chk({nm, "_mem_addr"}, {24'h0, mem_addr}, {24'h0, eaddr});
    if (eg0 && !we0) q0.push_back(erd);
    if (eg1 && !we1) q1.push_back(erd);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    drv(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    step("rst_a", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("rst_rvalid0", {31'h0, rvalid0}, 32'h0);
    chk("rst_rvalid1", {31'h0, rvalid1}, 32'h0);
    chk("rst_rdata0", {24'h0, rdata0}, 32'h0);
    chk("rst_rdata1", {24'h0, rdata1}, 32'h0);
    drv(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 1'b1, 8'h20, 8'h55, 1'b0);
    step("rst_b", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;

    // Basic read, hold, write-then-read, read-before-write ordering.
    drv(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step("rd10", 1'b1, 1'b0, 1'b0, 8'h10, 8'hA5);
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step("idle1", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step("idle2", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("hold_rdata0", {24'h0, rdata0}, 32'hA5);
    chk("hold_rvalid0", {31'h0, rvalid0}, 32'h0);
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h20, 8'h3C, 1'b0);
    step("wr20", 1'b0, 1'b1, 1'b1, 8'h20, 8'h00);
    drv(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step("rd20", 1'b1, 1'b0, 1'b0, 8'h20, 8'h3C);
    drv(1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step("rd30_old", 1'b1, 1'b0, 1'b0, 8'h30, 8'h30);
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h30, 8'h77, 1'b0);
    step("wr30", 1'b0, 1'b1, 1'b1, 8'h30, 8'h00);
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0);
    step("rd30_new", 1'b0, 1'b1, 1'b0, 8'h30, 8'h77);

    // Tie for 4 cycles; last=1 here so round-robin starts with port 0.
    drv(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      t1 = RR & (i[0] == 1'b1);
      step("tie", ~t1, t1, 1'b0, t1 ? 8'h02 : 8'h01, t1 ? 8'h02 : 8'h01);
    end

    // Lock with contention: 4 port-0 grants, forced break, then back to normal arbitration.
    drv(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      t1 = (i == 4);
      step("lock_brk", ~t1, t1, 1'b0, t1 ? 8'h02 : 8'h01, t1 ? 8'h02 : 8'h01);
    end
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step("unlock_idle", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Lock with no contention does not consume the budget.
    drv(1'b1, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step("lock_alone", 1'b1, 1'b0, 1'b0, 8'h03, 8'h03);
    drv(1'b1, 1'b0, 8'h03, 8'h00, 1'b1, 1'b1, 1'b0, 8'h04, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      t1 = (i == 4);
      step("lock_budget", ~t1, t1, 1'b0, t1 ? 8'h04 : 8'h03, t1 ? 8'h04 : 8'h03);
    end

    // Owner drops request while locked: port 1 granted in the same cycle.
    drv(1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step("own_lock", 1'b1, 1'b0, 1'b0, 8'h05, 8'h05);
    drv(1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 8'h06, 8'h00, 1'b0);
    step("own_hold", 1'b1, 1'b0, 1'b0, 8'h05, 8'h05);
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h06, 8'h99, 1'b0);
    step("own_drop", 1'b0, 1'b1, 1'b1, 8'h06, 8'h00);

    // Reset mid-operation: no grants, no writes, no rvalid.
    drv(1'b1, 1'b0, 8'h07, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step("pre_rst", 1'b1, 1'b0, 1'b0, 8'h07, 8'h07);
    rst = 1'b0;
    drv(1'b1, 1'b0, 8'h07, 8'h00, 1'b1, 1'b1, 1'b1, 8'h08, 8'hEE, 1'b0);
    step("mid_rst_a", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step("mid_rst_b", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step("post_rst", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("post_rst_rvalid0", {31'h0, rvalid0}, 32'h0);
    chk("post_rst_rvalid1", {31'h0, rvalid1}, 32'h0);
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0);
    step("post_rd8", 1'b0, 1'b1, 1'b0, 8'h08, 8'h08);
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step("drain1", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step("drain2", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    chk("q0_empty", q0.size(), 32'h0);
    chk("q1_empty", q1.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
